// File: rtl/irc_tx_arbiter.sv
// rtl/irc_tx_arbiter.sv - outbound IRC line arbiter: PONG priority, round-robin users, 510-byte truncation, CR LF append
// Optional build macro: IRC_FLOOD_GUARD_EN enables an idle gap of GAP_CYCLES after each non-PONG line.
module irc_tx_arbiter #(
    parameter int N_REQ       = 3,
    parameter int MAX_PAYLOAD = 510,
    parameter int GAP_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       trunc_pulse
);

    localparam int         GW       = $clog2(N_REQ);
    localparam logic [9:0] CNT_LAST = 10'(MAX_PAYLOAD - 1);
    localparam logic [9:0] CNT_SAT  = 10'h3FF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PASS  = 3'd1,
        S_DRAIN = 3'd2,
        S_CR    = 3'd3,
        S_LF    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [9:0]      byte_cnt_q, byte_cnt_d;

    logic            g_valid;
    logic [7:0]      g_data;
    logic            g_last;
    logic            rr_found;
    logic [GW-1:0]   rr_pick;
    logic            gap_block;

`ifdef IRC_FLOOD_GUARD_EN
    localparam int GAPW = $clog2(GAP_CYCLES + 1);
    logic [GAPW-1:0] gap_q, gap_d;

    assign gap_block = (gap_q != '0);

    // Gap counter: reloads after a non-PONG line completes, then counts down to zero
    always_comb begin
        gap_d = (gap_q != '0) ? gap_q - 1'b1 : '0;
        if (state_q == S_LF && out_ready && grant_q != '0) begin
            gap_d = GAPW'(GAP_CYCLES);
        end
    end

    // Gap counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`else
    logic unused_gap_cfg;
    assign gap_block      = 1'b0;
    assign unused_gap_cfg = (GAP_CYCLES > 0);
`endif

    // Mux out the granted port's stream signals
    always_comb begin
        g_valid = 1'b0;
        g_data  = 8'h00;
        g_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                g_valid = req_valid[i];
                g_data  = req_data[8*i +: 8];
                g_last  = req_last[i];
            end
        end
    end

    // Round-robin candidate among ports 1..N_REQ-1, starting after rr_ptr
    always_comb begin
        int p;
        rr_found = 1'b0;
        rr_pick  = '0;
        p        = 0;
        for (int k = 1; k < N_REQ; k++) begin
            p = int'(rr_ptr_q) + k;
            if (p >= N_REQ) begin
                p = p - (N_REQ - 1);
            end
            for (int i = 1; i < N_REQ; i++) begin
                if (i == p && !rr_found && req_valid[i]) begin
                    rr_found = 1'b1;
                    rr_pick  = GW'(i);
                end
            end
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= GW'(N_REQ - 1);
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Next-state logic: arbitration, payload counting, truncation, CR LF sequencing
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid[0]) begin
                    grant_d    = '0;
                    byte_cnt_d = '0;
                    state_d    = S_PASS;
                end else if (!gap_block && rr_found) begin
                    grant_d    = rr_pick;
                    byte_cnt_d = '0;
                    state_d    = S_PASS;
                end
            end
            S_PASS: begin
                if (g_valid && out_ready) begin
                    if (byte_cnt_q != CNT_SAT) begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                    end
                    if (g_last) begin
                        state_d = S_CR;
                    end else if (byte_cnt_q == CNT_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (g_valid && g_last) begin
                    state_d = S_CR;
                end
            end
            S_CR: begin
                if (out_ready) begin
                    state_d = S_LF;
                end
            end
            S_LF: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    if (grant_q != '0) begin
                        rr_ptr_d = grant_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: passthrough in PASS, silent accept in DRAIN, fixed CR/LF beats
    always_comb begin
        out_valid   = 1'b0;
        out_data    = 8'h00;
        req_ready   = '0;
        trunc_pulse = 1'b0;
        case (state_q)
            S_PASS: begin
                out_valid = g_valid;
                out_data  = g_data;
                for (int i = 0; i < N_REQ; i++) begin
                    if (grant_q == GW'(i)) begin
                        req_ready[i] = out_ready;
                    end
                end
                trunc_pulse = g_valid && out_ready && !g_last && (byte_cnt_q == CNT_LAST);
            end
            S_DRAIN: begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (grant_q == GW'(i)) begin
                        req_ready[i] = 1'b1;
                    end
                end
            end
            S_CR: begin
                out_valid = 1'b1;
                out_data  = 8'h0D;
            end
            S_LF: begin
                out_valid = 1'b1;
                out_data  = 8'h0A;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
        busy     = (state_q != S_IDLE);
        grant_id = grant_q;
    end

endmodule

// File: tb/tb_irc_tx_arbiter.sv
// tb/tb_irc_tx_arbiter.sv - directed self-checking bench for irc_tx_arbiter
module tb_irc_tx_arbiter;

    localparam int N = 3;
`ifdef IRC_FLOOD_GUARD_EN
    localparam int SETTLE = 70;
`else
    localparam int SETTLE = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;
    logic [1:0]       grant_id;
    logic             busy;
    logic             trunc_pulse;

    always #5 clk = ~clk;

    irc_tx_arbiter #(
        .N_REQ       (3),
        .MAX_PAYLOAD (510),
        .GAP_CYCLES  (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .trunc_pulse (trunc_pulse)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [8:0]  q2[$];
    logic [N-1:0] pen;
    logic        tog;
    logic [7:0]  outq[$];
    int          gq[$];
    logic [7:0]  ex_b[$];
    int          ex_g[$];
    int          rise_q[$];
    int          lf_q[$];
    int          busy_cnt, trunc_cnt, trunc_at, stall_err, idle_err;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic        s_busy, s_ov, s_tp;
    logic [7:0]  s_od;
    logic [N-1:0] s_rr;
    logic [1:0]  s_gid;
    int          en_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [8:0] qfront(input int i);
        if (qsize(i) == 0) return 9'h000;
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpush(input int i, input logic [8:0] v);
        case (i)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic qpop(input int i);
        case (i)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    function automatic logic pending();
        return (pen[0] && q0.size() > 0) || (pen[1] && q1.size() > 0) || (pen[2] && q2.size() > 0);
    endfunction

    task automatic apply_inputs();
        logic [8:0] f;
        for (int i = 0; i < N; i++) begin
            f = qfront(i);
            req_valid[i]       = pen[i] && (qsize(i) > 0);
            req_data[8*i +: 8] = req_valid[i] ? f[7:0] : 8'h00;
            req_last[i]        = req_valid[i] ? f[8] : 1'b0;
        end
    endtask

    task automatic load_line(input int port, input string s);
        for (int i = 0; i < s.len(); i++) begin
            qpush(port, {(i == s.len() - 1), s[i]});
        end
    endtask

    task automatic expect_raw(input string s, input int g);
        for (int i = 0; i < s.len(); i++) begin
            ex_b.push_back(s[i]);
            ex_g.push_back(g);
        end
    endtask

    task automatic expect_line(input string s, input int g);
        expect_raw(s, g);
        ex_b.push_back(8'h0D); ex_g.push_back(g);
        ex_b.push_back(8'h0A); ex_g.push_back(g);
    endtask

    task automatic cmp_out(input string tag);
        int e0;
        check({tag, "_len"}, outq.size(), ex_b.size());
        for (int i = 0; i < ex_b.size() && i < outq.size(); i++) begin
            e0 = n_errors;
            check({tag, "_byte"}, outq[i], ex_b[i]);
            check({tag, "_gnt"}, gq[i], ex_g[i]);
            if (n_errors != e0) break;
        end
        outq.delete(); gq.delete(); ex_b.delete(); ex_g.delete();
    endtask

    // one clock: sample 1 time unit before the rising edge, update producers at the falling edge
    task automatic tick();
        logic [N-1:0] xf;
        #4;
        xf = req_valid & req_ready;
        if (out_valid && !busy) idle_err++;
        if (prev_stall && (!out_valid || out_data != prev_data)) stall_err++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
            outq.push_back(out_data);
            gq.push_back(int'(grant_id));
            if (out_data == 8'h0A) lf_q.push_back(cyc);
        end
        if (trunc_pulse) begin
            trunc_cnt++;
            trunc_at = outq.size();
        end
        if (busy && !s_busy) rise_q.push_back(cyc);
        if (busy) busy_cnt++;
        s_busy = busy; s_ov = out_valid; s_od = out_data; s_rr = req_ready;
        s_gid = grant_id; s_tp = trunc_pulse;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) if (xf[i]) qpop(i);
        if (tog) out_ready = ~out_ready;
        apply_inputs();
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((s_busy || pending()) && n < budget);
        check({tag, "_timeout"}, int'(s_busy || pending()), 0);
    endtask

    task automatic settle();
        repeat (SETTLE) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1; pen = '0; out_ready = 1'b1; tog = 1'b0;
        busy_cnt = 0; trunc_cnt = 0; trunc_at = 0; stall_err = 0; idle_err = 0;
        prev_stall = 1'b0; prev_data = 8'h00; s_busy = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        apply_inputs();
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", s_ov, 0);
        check("rst_out_data", s_od, 0);
        check("rst_req_ready", s_rr, 0);
        check("rst_busy", s_busy, 0);
        check("rst_grant", s_gid, 0);
        check("rst_trunc", s_tp, 0);

        // 1: single user line with CR LF appended
        load_line(1, "NICK a");
        busy_cnt = 0; rise_q.delete();
        en_cyc = cyc;
        pen = 3'b010; apply_inputs();
        drain(100, "t1");
        expect_line("NICK a", 1);
        cmp_out("t1");
        check("t1_busy_cycles", busy_cnt, 8);
        check("t1_rise_n", rise_q.size(), 1);
        if (rise_q.size() > 0) check("t1_busy_rise", rise_q[0] - en_cyc, 1);

        // 2: PONG wins, then round-robin continues from port 1 (untouched by PONG)
        load_line(0, "PONG :x");
        load_line(1, "USER b");
        load_line(2, "hi");
        pen = 3'b111; apply_inputs();
        drain(400, "t2");
        expect_line("PONG :x", 0);
        expect_line("hi", 2);
        expect_line("USER b", 1);
        cmp_out("t2");

        // 3a: one-byte lines alternate between ports 2 and 1
        load_line(1, "a"); load_line(1, "b"); load_line(1, "c");
        load_line(2, "x"); load_line(2, "y"); load_line(2, "z");
        pen = 3'b110; apply_inputs();
        drain(2000, "t3a");
        expect_line("x", 2); expect_line("a", 1);
        expect_line("y", 2); expect_line("b", 1);
        expect_line("z", 2); expect_line("c", 1);
        cmp_out("t3a");

        // 3b: PONG raised mid-line waits for LF, then beats waiting port 2
        settle();
        load_line(1, "abcd");
        pen = 3'b010; apply_inputs();
        tick(); tick(); tick();
        load_line(0, "P"); load_line(2, "q");
        pen = 3'b111; apply_inputs();
        drain(400, "t3b");
        expect_line("abcd", 1); expect_line("P", 0); expect_line("q", 2);
        cmp_out("t3b");

        // 4: 600-byte line truncated to 510 payload bytes
        settle();
        for (int i = 0; i < 600; i++) begin
            b = 8'h40 + 8'(i % 32);
            qpush(1, {(i == 599), b});
        end
        trunc_cnt = 0; trunc_at = 0;
        pen = 3'b010; apply_inputs();
        drain(1500, "t4");
        for (int i = 0; i < 510; i++) begin
            b = 8'h40 + 8'(i % 32);
            ex_b.push_back(b); ex_g.push_back(1);
        end
        ex_b.push_back(8'h0D); ex_g.push_back(1);
        ex_b.push_back(8'h0A); ex_g.push_back(1);
        cmp_out("t4");
        check("t4_trunc_count", trunc_cnt, 1);
        check("t4_trunc_at", trunc_at, 510);
        check("t4_all_accepted", q1.size(), 0);

        // 5a: toggling out_ready including CR/LF beats
        settle();
        load_line(1, "ABCD");
        stall_err = 0;
        tog = 1'b1;
        pen = 3'b010; apply_inputs();
        drain(200, "t5a");
        tog = 1'b0; out_ready = 1'b1; apply_inputs();
        expect_line("ABCD", 1);
        cmp_out("t5a");
        check("t5a_stall_stable", stall_err, 0);

        // 5b: reset on the third payload byte abandons the line; rr restarts at port 1
        settle();
        load_line(1, "WXYZ");
        pen = 3'b010; apply_inputs();
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_line(2, "r");
        pen = 3'b110; apply_inputs();
        tick();
        check("t5b_rst_out_valid", s_ov, 0);
        check("t5b_rst_out_data", s_od, 0);
        check("t5b_rst_req_ready", s_rr, 0);
        check("t5b_rst_busy", s_busy, 0);
        check("t5b_rst_grant", s_gid, 0);
        check("t5b_rst_trunc", s_tp, 0);
        drain(400, "t5b");
        expect_raw("WXY", 1);
        expect_line("Z", 1);
        expect_line("r", 2);
        cmp_out("t5b");

`ifdef IRC_FLOOD_GUARD_EN
        // 6: flood guard gap between port-1 lines; PONG exempt during the gap
        settle();
        rise_q.delete(); lf_q.delete();
        load_line(1, "a"); load_line(1, "b");
        pen = 3'b010; apply_inputs();
        drain(400, "t6a");
        check("t6_rise_n", rise_q.size(), 2);
        if (rise_q.size() == 2 && lf_q.size() == 2) check("t6_gap", rise_q[1] - lf_q[0], 66);
        repeat (8) tick();
        load_line(0, "P");
        pen = 3'b011; apply_inputs();
        drain(100, "t6b");
        check("t6_rise_n2", rise_q.size(), 3);
        if (rise_q.size() == 3 && lf_q.size() >= 2) check("t6_pong_in_gap", rise_q[2] - lf_q[1], 11);
        expect_line("a", 1); expect_line("b", 1); expect_line("P", 0);
        cmp_out("t6");
`endif

        check("idle_never_valid", idle_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irc_tx_arbiter.md
Name: irc_tx_arbiter

Overview:
Shares the single outbound TCP byte channel between several line producers: the PING auto-responder (PONG), the user-command path and the channel message path.
- Grants one requester at a time for a whole line.
- Passes the line's payload bytes through, then appends CR LF.
- Enforces the IRC 510-byte payload limit by truncating longer lines.
- PONG traffic has fixed top priority so server keepalives never starve.

Parameters:
N_REQ, 3, number of requesters; port 0 is the PONG path (fixed priority), ports 1..N_REQ-1 are round-robin; N_REQ >= 2.
MAX_PAYLOAD, 510, maximum payload bytes per line, excluding CR LF.
GAP_CYCLES, 64, minimum idle cycles between lines from non-priority ports (only with IRC_FLOOD_GUARD_EN).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  N_REQ  per-port byte valid.
req_data  in  8*N_REQ  per-port byte; port i occupies bits [8i+7:8i].
req_last  in  N_REQ  marks the final payload byte of a line; producers never send CR/LF.
req_ready  out  N_REQ  per-port byte accepted.
out_valid  out  1  byte valid toward the TCP writer.
out_data  out  8  outbound byte.
out_ready  in  1  TCP writer accepts the byte.
grant_id  out  $clog2(N_REQ)  currently granted port; valid while busy=1.
busy  out  1  high in every state except IDLE.
trunc_pulse  out  1  one-cycle pulse when a line hits MAX_PAYLOAD.

Behaviour:
- Reset values: state=IDLE, out_valid=0, out_data=0, req_ready=0, busy=0, grant_id=0, trunc_pulse=0, byte_cnt=0, rr_ptr=N_REQ-1 (the first round-robin grant after reset goes to port 1), gap counter=0.
- A transfer is any cycle with valid&ready on that interface.
- IDLE:
  - If req_valid[0]=1, grant port 0.
  - Otherwise scan ports rr_ptr+1 .. wrapping, skipping port 0, and grant the first valid port.
  - Register grant_id, clear byte_cnt, go to PASS.
  - Arbitration latency is one cycle: out_valid is never high in IDLE.
- PASS:
  - Combinational passthrough: out_valid=req_valid[g], out_data=req_data[g], req_ready[g]=out_ready; all other req_ready=0.
  - byte_cnt increments on each transfer.
  - On a transfer with req_last[g]=1, go to CR.
  - On a transfer where byte_cnt becomes MAX_PAYLOAD and req_last[g]=0: pulse trunc_pulse and go to DRAIN.
  - On a transfer where byte_cnt becomes MAX_PAYLOAD and req_last[g]=1: no truncation, go to CR.
- DRAIN:
  - out_valid=0 and req_ready[g]=1; bytes are discarded.
  - On a transfer with req_last, go to CR.
- CR: out_valid=1, out_data=8'h0D, all req_ready=0. On out_ready, go to LF.
- LF: out_valid=1, out_data=8'h0A. On out_ready, go to IDLE. If g!=0, set rr_ptr=g and load the gap counter.
- rr_ptr is never updated by port-0 grants.
- A grant holds for the whole line. Requests arriving mid-line, including port 0, wait for LF to complete.
- byte_cnt is 10 bits wide and saturates; it never wraps.
- out_valid, once high, holds with stable out_data until out_ready (PASS relies on producers holding valid/data until ready).
- A single-byte line (last on the first byte) produces 3 output bytes.
- rst asserted mid-line returns every register to its reset value on the next edge. The partial line is abandoned with no CR LF; the producers handle the restart.

Optional Feature:
IRC_FLOOD_GUARD_EN
- Defined: after LF of a line from port g!=0, a counter loads GAP_CYCLES and decrements each cycle.
  - While it is nonzero, IDLE ignores ports 1..N_REQ-1.
  - Port 0 is exempt and may be granted during the gap; the counter keeps running during its line.
  - busy stays 0 during the gap.
- Undefined: no counter exists and lines from any port may be granted the cycle after LF completes. GAP_CYCLES is unused.

Test Plan:
1. Port 1 sends "NICK a" (6 bytes, last on 'a'), out_ready=1 -> out stream "NICK a\r\n" (8 bytes); grant_id=1; busy high from the cycle after req_valid through the LF transfer.
2. Ports 0 and 2 valid in the same IDLE cycle -> port 0 line (e.g. "PONG :x") sent completely first, then port 2; rr_ptr unchanged by the port-0 line.
3. Ports 1 and 2 each send continuous one-byte lines -> grants alternate 1,2,1,2; port 0 raised mid-line on port 1 -> waits until after port 1's LF, then is granted before port 2.
4. Port 1 sends a 600-byte line -> exactly 510 payload bytes plus CR LF out; trunc_pulse high for one cycle on byte 510; the remaining 90 bytes are accepted with out_valid=0.
5. out_ready toggled 1,0,1,0 during a 4-byte line, including the CR/LF beats -> no byte dropped or duplicated, out_data stable while stalled; rst pulsed at the 3rd payload byte -> all outputs at reset values, next grant goes to port 1.
6. With IRC_FLOOD_GUARD_EN, GAP_CYCLES=64: port 1 sends two back-to-back lines -> second grant no earlier than 64 cycles after the first LF; a port-0 request at gap cycle 10 is granted at cycle 11.
